dnn2ami_rd_path: RTL and testbench



---
 rtl/dnn2ami_rd_path.sv | 187 ++++++++++++++++++
 tb/tb_dnn2ami_rd_path.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dnn2ami_rd_path.sv
// dnn2ami_rd_path: splits macro read requests into AMI bursts and
// steers the in-order response beats into the selected PU input buffer.
module dnn2ami_rd_path #(
    parameter int NUM_PU         = 2,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 64,
    parameter int TX_SIZE_WIDTH  = 10,
    parameter int MAX_BURST      = 16,
    parameter int LOG_DEPTH      = 3,
    parameter int LOG_OUTST      = 2,
    parameter int NUM_PU_W       = $clog2(NUM_PU) + 1
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      rd_req,
    input  logic [AXI_ADDR_WIDTH-1:0] rd_req_addr,
    input  logic [TX_SIZE_WIDTH-1:0]  rd_req_size,
    input  logic [NUM_PU_W-1:0]       rd_req_pu,
    output logic                      rd_ready,
    output logic                      mem_req_valid,
    output logic [AXI_ADDR_WIDTH-1:0] mem_req_addr,
    output logic [TX_SIZE_WIDTH-1:0]  mem_req_len,
    input  logic                      mem_req_ready,
    input  logic                      mem_resp_valid,
    input  logic [AXI_DATA_WIDTH-1:0] mem_resp_data,
    output logic                      mem_resp_ready,
    output logic [NUM_PU-1:0]         inbuf_push,
    output logic [AXI_DATA_WIDTH-1:0] inbuf_data,
    input  logic [NUM_PU-1:0]         inbuf_full,
    output logic                      busy,
    output logic                      err
);

    localparam int BPB_LOG = $clog2(AXI_DATA_WIDTH / 8);
    localparam int DEPTH   = 1 << LOG_DEPTH;
    localparam int OUTST   = 1 << LOG_OUTST;
    localparam logic [TX_SIZE_WIDTH-1:0] MAXB  = TX_SIZE_WIDTH'(MAX_BURST);
    localparam logic [TX_SIZE_WIDTH-1:0] ONE_T = TX_SIZE_WIDTH'(1);
    localparam logic [NUM_PU_W-1:0]      NPU   = NUM_PU_W'(NUM_PU);
    localparam logic [LOG_DEPTH:0]       ONE_M = (LOG_DEPTH + 1)'(1);
    localparam logic [LOG_OUTST:0]       ONE_O = (LOG_OUTST + 1)'(1);

    typedef enum logic {IDLE, ISSUE} state_t;

    logic [AXI_ADDR_WIDTH-1:0] mq_addr_q [DEPTH];
    logic [TX_SIZE_WIDTH-1:0]  mq_size_q [DEPTH];
    logic [NUM_PU_W-1:0]       mq_pu_q   [DEPTH];
    logic [LOG_DEPTH:0]        mq_wr_q, mq_rd_q;
    logic [LOG_DEPTH-1:0]      mq_widx, mq_ridx;
    logic                      mq_full, mq_empty, mq_push, mq_pop;
    logic                      accept, bad_pu, init_q, err_q;

    logic [NUM_PU_W-1:0]       tq_pu_q  [OUTST];
    logic [TX_SIZE_WIDTH-1:0]  tq_len_q [OUTST];
    logic [LOG_OUTST:0]        tq_wr_q, tq_rd_q;
    logic [LOG_OUTST-1:0]      tq_widx, tq_ridx;
    logic                      tq_full, tq_empty;
    logic [NUM_PU_W-1:0]       head_pu;
    logic [TX_SIZE_WIDTH-1:0]  head_len, cnt_q;
    logic                      head_full, beat_hs, last_beat;

    state_t                    state_q;
    logic [AXI_ADDR_WIDTH-1:0] addr_q;
    logic [TX_SIZE_WIDTH-1:0]  rem_q, burst_len;
    logic [NUM_PU_W-1:0]       pu_q;
    logic                      req_hs;

    assign mq_widx  = mq_wr_q[LOG_DEPTH-1:0];
    assign mq_ridx  = mq_rd_q[LOG_DEPTH-1:0];
    assign mq_empty = (mq_wr_q == mq_rd_q);
    assign mq_full  = (mq_wr_q[LOG_DEPTH] != mq_rd_q[LOG_DEPTH]) &&
                      (mq_widx == mq_ridx);
    assign rd_ready = init_q && !mq_full;
    assign accept   = rd_req && rd_ready;
    assign bad_pu   = (rd_req_pu >= NPU);
    // Empty and misrouted requests are consumed here and never queued.
    assign mq_push  = accept && !bad_pu && (rd_req_size != '0);
    assign mq_pop   = (state_q == IDLE) && !mq_empty;
    assign err      = err_q;

    always_ff @(posedge clock) begin
        if (mq_push) begin
            mq_addr_q[mq_widx] <= rd_req_addr;
            mq_size_q[mq_widx] <= rd_req_size;
            mq_pu_q[mq_widx]   <= rd_req_pu;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mq_wr_q <= '0;
            mq_rd_q <= '0;
            init_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            init_q <= 1'b1;
            if (mq_push) mq_wr_q <= mq_wr_q + ONE_M;
            if (mq_pop)  mq_rd_q <= mq_rd_q + ONE_M;
            if (accept && bad_pu) err_q <= 1'b1;
        end
    end

    assign burst_len     = (rem_q > MAXB) ? MAXB : rem_q;
    assign mem_req_valid = (state_q == ISSUE) && !tq_full;
    assign mem_req_addr  = addr_q;
    assign mem_req_len   = burst_len;
    assign req_hs        = mem_req_valid && mem_req_ready;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            pu_q    <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (!mq_empty) begin
                        addr_q  <= mq_addr_q[mq_ridx];
                        rem_q   <= mq_size_q[mq_ridx];
                        pu_q    <= mq_pu_q[mq_ridx];
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (req_hs) begin
                        addr_q <= addr_q +
                            (AXI_ADDR_WIDTH'(burst_len) << BPB_LOG);
                        rem_q  <= rem_q - burst_len;
                        if (rem_q == burst_len) state_q <= IDLE;
                    end
                end
            endcase
        end
    end

    assign tq_widx  = tq_wr_q[LOG_OUTST-1:0];
    assign tq_ridx  = tq_rd_q[LOG_OUTST-1:0];
    assign tq_empty = (tq_wr_q == tq_rd_q);
    assign tq_full  = (tq_wr_q[LOG_OUTST] != tq_rd_q[LOG_OUTST]) &&
                      (tq_widx == tq_ridx);
    assign head_pu  = tq_pu_q[tq_ridx];
    assign head_len = tq_len_q[tq_ridx];

    always_comb begin
        head_full = 1'b0;
        for (int p = 0; p < NUM_PU; p++)
            if (head_pu == NUM_PU_W'(p)) head_full = inbuf_full[p];
    end

    assign mem_resp_ready = !tq_empty && !head_full;
    assign beat_hs        = mem_resp_valid && mem_resp_ready;
    assign last_beat      = beat_hs && (cnt_q == head_len - ONE_T);
    assign inbuf_data     = beat_hs ? mem_resp_data : '0;

    always_comb begin
        inbuf_push = '0;
        for (int p = 0; p < NUM_PU; p++)
            if (beat_hs && head_pu == NUM_PU_W'(p)) inbuf_push[p] = 1'b1;
    end

    always_ff @(posedge clock) begin
        if (req_hs) begin
            tq_pu_q[tq_widx]  <= pu_q;
            tq_len_q[tq_widx] <= burst_len;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tq_wr_q <= '0;
            tq_rd_q <= '0;
            cnt_q   <= '0;
        end else begin
            if (req_hs) tq_wr_q <= tq_wr_q + ONE_O;
            if (last_beat) begin
                tq_rd_q <= tq_rd_q + ONE_O;
                cnt_q   <= '0;
            end else if (beat_hs) begin
                cnt_q <= cnt_q + ONE_T;
            end
        end
    end

    assign busy = !mq_empty || (state_q == ISSUE) || !tq_empty;

endmodule

// File: tb/tb_dnn2ami_rd_path.sv
// Directed bench for dnn2ami_rd_path with a simple in-order memory
// responder; beat data is the byte address of the beat.
module tb_dnn2ami_rd_path;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        rd_req = 1'b0;
    logic [31:0] rd_req_addr = '0;
    logic [9:0]  rd_req_size = '0;
    logic [1:0]  rd_req_pu = '0;
    logic        rd_ready;
    logic        mem_req_valid;
    logic [31:0] mem_req_addr;
    logic [9:0]  mem_req_len;
    logic        mem_req_ready = 1'b0;
    logic        mem_resp_valid = 1'b0;
    logic [63:0] mem_resp_data = '0;
    logic        mem_resp_ready;
    logic [1:0]  inbuf_push;
    logic [63:0] inbuf_data;
    logic [1:0]  inbuf_full = '0;
    logic        busy;
    logic        err;

    int checks = 0;
    int failures = 0;
    bit resp_en = 1'b0;

    logic [31:0] req_addr_log[$];
    logic [9:0]  req_len_log[$];
    logic [63:0] beatq[$];
    logic [63:0] got0[$];
    logic [63:0] got1[$];

    always #5 clock = ~clock;

    dnn2ami_rd_path dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .rd_req         (rd_req),
        .rd_req_addr    (rd_req_addr),
        .rd_req_size    (rd_req_size),
        .rd_req_pu      (rd_req_pu),
        .rd_ready       (rd_ready),
        .mem_req_valid  (mem_req_valid),
        .mem_req_addr   (mem_req_addr),
        .mem_req_len    (mem_req_len),
        .mem_req_ready  (mem_req_ready),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data),
        .mem_resp_ready (mem_resp_ready),
        .inbuf_push     (inbuf_push),
        .inbuf_data     (inbuf_data),
        .inbuf_full     (inbuf_full),
        .busy           (busy),
        .err            (err)
    );

    // Memory responder: presents the oldest pending beat.
    initial forever begin
        @(negedge clock);
        #1;
        if (resp_en && beatq.size() > 0) begin
            mem_resp_valid = 1'b1;
            mem_resp_data  = beatq[0];
        end else begin
            mem_resp_valid = 1'b0;
            mem_resp_data  = '0;
        end
    end

    // Observe handshakes just before the next rising edge.
    initial forever begin
        @(negedge clock);
        #3;
        if (reset_n && mem_req_valid && mem_req_ready) begin
            req_addr_log.push_back(mem_req_addr);
            req_len_log.push_back(mem_req_len);
            for (int i = 0; i < int'(mem_req_len); i++)
                beatq.push_back({32'h0, mem_req_addr + 32'(8 * i)});
        end
        if (reset_n && mem_resp_valid && mem_resp_ready && beatq.size() > 0)
            void'(beatq.pop_front());
        if (inbuf_push[0]) got0.push_back(inbuf_data);
        if (inbuf_push[1]) got1.push_back(inbuf_data);
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        req_addr_log.delete();
        req_len_log.delete();
        got0.delete();
        got1.delete();
    endtask

    // Entered at a falling edge; returns at the falling edge after accept.
    task automatic send(input logic [31:0] a, input logic [9:0] s,
                        input logic [1:0] p);
        int n;
        n = 0;
        rd_req = 1'b1;
        rd_req_addr = a;
        rd_req_size = s;
        rd_req_pu = p;
        #3;
        while (!rd_ready && n < 200) begin
            @(negedge clock);
            #3;
            n++;
        end
        chk("send_accept", 64'(n < 200), 64'd1);
        @(negedge clock);
        rd_req = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy && n < 2000) begin
            @(negedge clock);
            n++;
        end
        chk(tag, 64'(n < 2000), 64'd1);
        repeat (2) @(negedge clock);
    endtask

    task automatic check_stream(input string tag, input int pu,
                                input logic [31:0] base, input int n);
        logic [63:0] q[$];
        int bad;
        bad = 0;
        if (pu == 0) q = got0;
        else q = got1;
        chk({tag, "_cnt"}, 64'(q.size()), 64'(n));
        for (int i = 0; i < q.size() && i < n; i++)
            if (q[i] !== {32'h0, base + 32'(8 * i)}) bad++;
        chk({tag, "_data"}, 64'(bad), 64'd0);
    endtask

    initial begin
        int n;
        int sz;
        #1;
        chk("rst_rd_ready", 64'(rd_ready), 64'd0);
        chk("rst_req_valid", 64'(mem_req_valid), 64'd0);
        chk("rst_resp_ready", 64'(mem_resp_ready), 64'd0);
        chk("rst_push", 64'(inbuf_push), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        chk("post_rst_ready", 64'(rd_ready), 64'd1);

        // Single 40-beat request to PU1
        mem_req_ready = 1'b1;
        resp_en = 1'b1;
        send(32'h1000, 10'd40, 2'd1);
        chk("lat_t1_valid", 64'(mem_req_valid), 64'd0);
        @(negedge clock);
        chk("lat_t2_valid", 64'(mem_req_valid), 64'd1);
        chk("lat_t2_addr", 64'(mem_req_addr), 64'h1000);
        chk("lat_t2_len", 64'(mem_req_len), 64'd16);
        wait_idle("t1_idle");
        chk("t1_nbursts", 64'(req_addr_log.size()), 64'd3);
        chk("t1_b0", {req_addr_log[0], 22'h0, req_len_log[0]},
            {32'h1000, 22'h0, 10'd16});
        chk("t1_b1", {req_addr_log[1], 22'h0, req_len_log[1]},
            {32'h1080, 22'h0, 10'd16});
        chk("t1_b2", {req_addr_log[2], 22'h0, req_len_log[2]},
            {32'h1100, 22'h0, 10'd8});
        check_stream("t1_pu1", 1, 32'h1000, 40);
        chk("t1_pu0_cnt", 64'(got0.size()), 64'd0);
        chk("t1_busy", 64'(busy), 64'd0);

        // Macro queue fill while the issuer is stalled on one request
        clear_logs();
        mem_req_ready = 1'b0;
        send(32'h2000, 10'd16, 2'd0);
        repeat (2) @(negedge clock);
        for (int k = 0; k < 8; k++)
            send(32'h3000 + 32'(k * 256), 10'd4, 2'(k % 2));
        chk("q_full_ready", 64'(rd_ready), 64'd0);
        chk("q_stall_valid", 64'(mem_req_valid), 64'd1);
        rd_req = 1'b1;
        rd_req_addr = 32'h4000;
        rd_req_size = 10'd4;
        rd_req_pu = 2'd1;
        repeat (3) @(negedge clock);
        chk("q9_held", 64'(rd_ready), 64'd0);
        chk("q_stall_addr", 64'(mem_req_addr), 64'h2000);
        chk("q_stall_len", 64'(mem_req_len), 64'd16);
        mem_req_ready = 1'b1;
        n = 0;
        #3;
        while (!rd_ready && n < 20) begin
            @(negedge clock);
            #3;
            n++;
        end
        chk("q9_wait", 64'(n), 64'd2);
        @(negedge clock);
        rd_req = 1'b0;
        wait_idle("t2_idle");
        chk("t2_nbursts", 64'(req_addr_log.size()), 64'd10);
        chk("t2_b8_addr", 64'(req_addr_log[8]), 64'h3700);
        chk("t2_b9", {req_addr_log[9], 22'h0, req_len_log[9]},
            {32'h4000, 22'h0, 10'd4});
        chk("t2_pu0_cnt", 64'(got0.size()), 64'd32);
        chk("t2_pu0_16", got0[16], 64'h3000);
        chk("t2_pu0_31", got0[31], 64'h3618);
        chk("t2_pu1_cnt", 64'(got1.size()), 64'd20);
        chk("t2_pu1_0", got1[0], 64'h3100);
        chk("t2_pu1_19", got1[19], 64'h4018);

        // Tag queue full: four bursts outstanding, no responses
        clear_logs();
        resp_en = 1'b0;
        send(32'h5000, 10'd80, 2'd0);
        repeat (10) @(negedge clock);
        chk("tq_full_valid", 64'(mem_req_valid), 64'd0);
        chk("tq_full_nb", 64'(req_addr_log.size()), 64'd4);
        chk("tq_full_busy", 64'(busy), 64'd1);
        resp_en = 1'b1;
        repeat (15) @(negedge clock);
        chk("tq_15_valid", 64'(mem_req_valid), 64'd0);
        @(negedge clock);
        chk("tq_16_valid", 64'(mem_req_valid), 64'd1);
        chk("tq_16_addr", 64'(mem_req_addr), 64'h5200);
        chk("tq_16_nb", 64'(req_addr_log.size()), 64'd4);
        @(negedge clock);
        chk("tq_17_nb", 64'(req_addr_log.size()), 64'd5);
        wait_idle("t3_idle");
        check_stream("t3_pu0", 0, 32'h5000, 80);

        // Back-pressure from a full PU0 input buffer
        clear_logs();
        send(32'h6000, 10'd16, 2'd0);
        n = 0;
        while (got0.size() < 4 && n < 50) begin
            @(negedge clock);
            n++;
        end
        chk("bp_start", 64'(n < 50), 64'd1);
        inbuf_full = 2'b01;
        #3;
        chk("bp_resp_ready", 64'(mem_resp_ready), 64'd0);
        chk("bp_push", 64'(inbuf_push), 64'd0);
        sz = got0.size();
        repeat (3) @(negedge clock);
        chk("bp_no_push", 64'(got0.size()), 64'(sz));
        chk("bp_busy", 64'(busy), 64'd1);
        inbuf_full = 2'b00;
        wait_idle("t4_idle");
        check_stream("t4_pu0", 0, 32'h6000, 16);

        // Zero-size and out-of-range PU requests are dropped
        clear_logs();
        send(32'h7000, 10'd0, 2'd0);
        chk("z_err", 64'(err), 64'd0);
        chk("z_busy", 64'(busy), 64'd0);
        send(32'h7100, 10'd8, 2'd3);
        chk("bad_err", 64'(err), 64'd1);
        repeat (4) @(negedge clock);
        chk("bad_nb", 64'(req_addr_log.size()), 64'd0);
        chk("bad_busy", 64'(busy), 64'd0);
        send(32'h7200, 10'd8, 2'd0);
        wait_idle("t5_idle");
        chk("t5_nb", 64'(req_addr_log.size()), 64'd1);
        chk("t5_b0", {req_addr_log[0], 22'h0, req_len_log[0]},
            {32'h7200, 22'h0, 10'd8});
        check_stream("t5_pu0", 0, 32'h7200, 8);
        chk("t5_err_sticky", 64'(err), 64'd1);

        // Address wrap across the top of the 32-bit space
        clear_logs();
        send(32'hFFFF_FFC0, 10'd24, 2'd1);
        wait_idle("t6_idle");
        chk("wrap_nb", 64'(req_addr_log.size()), 64'd2);
        chk("wrap_b0", {req_addr_log[0], 22'h0, req_len_log[0]},
            {32'hFFFF_FFC0, 22'h0, 10'd16});
        chk("wrap_b1", {req_addr_log[1], 22'h0, req_len_log[1]},
            {32'h0000_0040, 22'h0, 10'd8});
        check_stream("wrap_pu1", 1, 32'hFFFF_FFC0, 24);

        // Reset in the middle of a long transfer
        clear_logs();
        send(32'h8000, 10'd64, 2'd0);
        repeat (6) @(negedge clock);
        chk("mid_busy", 64'(busy), 64'd1);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(mem_req_valid), 64'd0);
        chk("mid_rst_rready", 64'(mem_resp_ready), 64'd0);
        chk("mid_rst_push", 64'(inbuf_push), 64'd0);
        chk("mid_rst_data", inbuf_data, 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_err", 64'(err), 64'd0);
        chk("mid_rst_ready", 64'(rd_ready), 64'd0);
        beatq.delete();
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        beatq.delete();
        clear_logs();
        repeat (2) @(negedge clock);
        chk("post_mid_ready", 64'(rd_ready), 64'd1);
        chk("post_mid_busy", 64'(busy), 64'd0);
        send(32'h9000, 10'd4, 2'd1);
        wait_idle("t7_idle");
        check_stream("t7_pu1", 1, 32'h9000, 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
